// File: rtl/sort_pkg.sv
// Shared constants and state type for the sorting-network front end.
package sort_pkg;

  localparam int unsigned SORT_WIDTH = 32;
  localparam int unsigned SORT_N     = 6;
  localparam int unsigned SORT_CW    = $clog2(SORT_N + 1);

  // All-ones pad sorts above every real word.
  localparam logic [SORT_WIDTH-1:0] SORT_PAD = '1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } load_state_e;

endpackage

// File: rtl/sort_frame_loader_if.sv
// Serial word input and parallel frame output handshakes of the frame loader.
interface sort_frame_loader_if
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_WIDTH,
  parameter int unsigned N     = SORT_N,
  parameter int unsigned CW    = $clog2(N + 1)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;

  // Word source / frame sink side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/sort_frame_loader.sv
// Packs a serial word stream into one N-slot frame for the sorting network.
// Short frames are padded so the pad value sorts to the top outputs.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int unsigned      WIDTH = SORT_WIDTH,
  parameter int unsigned      N     = SORT_N,
  parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}},
  parameter int unsigned      CW    = $clog2(N + 1)
) (
  input logic                clk,
  input logic                rst,
  sort_frame_loader_if.slave bus
);

  localparam int unsigned    IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

  load_state_e      state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] slot_q [N];
  logic [WIDTH-1:0] slot_d [N];
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;

  logic             in_ready_c;
  logic             accept_c;
  logic [N*WIDTH-1:0] out_data_c;

  // Ready follows the state but is forced low while reset is asserted.
  assign in_ready_c = (state_q == FILL) & ~rst;
  assign accept_c   = bus.in_valid & in_ready_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, slot write/pad, count and valid logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    count_d = count_q;
    valid_d = valid_q;

    unique case (state_q)
      FILL: begin
        if (accept_c) begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IW'(k)) begin
              slot_d[k] = bus.in_data;
            end
          end
          if (bus.in_last || (idx_q == IDX_LAST)) begin
            // Close: every slot above the last written one becomes PAD.
            for (int k = 0; k < N; k++) begin
              if (IW'(k) > idx_q) begin
                slot_d[k] = PAD;
              end
            end
            count_d = CW'(idx_q) + CW'(1);
            idx_d   = '0;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = FILL;
        end
      end
    endcase
  end

  // Datapath registers: slot index, slots, count and frame-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Flatten slot registers onto the parallel bus, slot 0 in the low bits.
  always_comb begin
    out_data_c = '0;
    for (int k = 0; k < N; k++) begin
      out_data_c[k*WIDTH +: WIDTH] = slot_q[k];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = out_data_c;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench for sort_frame_loader: a frame-level model fills the
// expected queue as words are accepted; a monitor pops on every transfer.
module tb_sort_frame_loader;
  import sort_pkg::*;

  localparam int unsigned W  = SORT_WIDTH;
  localparam int unsigned N  = SORT_N;
  localparam int unsigned CW = SORT_CW;
  localparam int unsigned FW = W * N;
  localparam logic [W-1:0] PAD = '1;

  typedef struct {
    logic [FW-1:0] data;
    int            count;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sort_frame_loader_if #(.WIDTH(W), .N(N), .CW(CW)) bus ();

  sort_frame_loader #(.WIDTH(W), .N(N), .PAD(PAD), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  frame_t       exp_q[$];
  logic [W-1:0] cur_q[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: collect words; a frame ends on last or when N words are held.
  function automatic bit model_accept(input logic [W-1:0] d, input logic last);
    frame_t f;
    cur_q.push_back(d);
    if (last || cur_q.size() == N) begin
      f.data = '0;
      for (int k = 0; k < N; k++) begin
        f.data[k*W +: W] = (k < cur_q.size()) ? cur_q[k] : PAD;
      end
      f.count = cur_q.size();
      exp_q.push_back(f);
      cur_q.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Offer one word after 'gap' idle cycles; tasks start and end at posedge+1.
  task automatic send_word(input logic [W-1:0] d, input logic last, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", FW'(0), FW'(1));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (model_accept(d, last)) begin
      @(negedge clk);
      chk("close_latency_valid", FW'(bus.out_valid), FW'(1));
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", FW'(bus.in_ready), FW'(0));
    chk("rst_out_valid", FW'(bus.out_valid), FW'(0));
    chk("rst_out_count", FW'(bus.out_count), FW'(0));
    chk("rst_out_data", bus.out_data, FW'(0));
    cur_q.delete();
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare transfers, hold stability and the post-handoff bubble.
  logic          hold_seen = 1'b0;
  logic          handoff   = 1'b0;
  logic [FW-1:0] prev_data;
  logic [CW-1:0] prev_count;
  always @(negedge clk) begin
    frame_t f;
    if (rst) begin
      hold_seen = 1'b0;
      handoff   = 1'b0;
    end else begin
      if (handoff) begin
        chk("bubble_in_ready", FW'(bus.in_ready), FW'(1));
        chk("bubble_out_valid", FW'(bus.out_valid), FW'(0));
        handoff = 1'b0;
      end
      if (bus.out_valid) begin
        if (hold_seen) begin
          chk("hold_data_stable", bus.out_data, prev_data);
          chk("hold_count_stable", FW'(bus.out_count), FW'(prev_count));
        end
        prev_data  = bus.out_data;
        prev_count = bus.out_count;
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", FW'(1), FW'(0));
          end else begin
            f = exp_q.pop_front();
            chk("frame_data", bus.out_data, f.data);
            chk("frame_count", FW'(bus.out_count), FW'(f.count));
          end
          hold_seen = 1'b0;
          handoff   = 1'b1;
        end else begin
          hold_seen = 1'b1;
        end
      end else begin
        hold_seen = 1'b0;
      end
    end
  end

  logic [W-1:0] t1 [6];
  logic [W-1:0] t4 [12];

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", FW'(bus.in_ready), FW'(0));
    chk("reset_out_valid", FW'(bus.out_valid), FW'(0));
    chk("reset_out_count", FW'(bus.out_count), FW'(0));
    chk("reset_out_data", bus.out_data, FW'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Full frame, last on the N-th word.
    t1 = '{32'd4, 32'd1, 32'd2, 32'd5, 32'd3, 32'd7};
    for (int i = 0; i < 6; i++) send_word(t1[i], i == 5, 0);
    repeat (2) @(posedge clk);
    #1;

    // Short frame padded to N.
    send_word(32'd9, 1'b0, 0);
    send_word(32'd2, 1'b0, 1);
    send_word(32'd8, 1'b1, 0);

    // Backpressure: frame held, a waiting word is ignored until handoff.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_word(W'(100 + i), 1'b0, 0);
    fork
      begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_in_ready_low", FW'(bus.in_ready), FW'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      send_word(32'hAA, 1'b1, 0);
    join

    // Twelve words with no last split into two full frames.
    t4 = '{32'd1, 32'd16, 32'd12, 32'd14, 32'd15, 32'd8,
           32'd3, 32'd4, 32'd9, 32'd19, 32'd2, 32'd9};
    for (int i = 0; i < 12; i++) send_word(t4[i], 1'b0, 0);

    // Reset mid-fill discards the partial frame.
    for (int i = 0; i < 3; i++) send_word(W'(50 + i), 1'b0, 0);
    async_reset();
    for (int i = 0; i < 6; i++) send_word(W'(60 + i), 1'b0, 0);

    // Reset mid-hold discards the pending frame.
    bus.out_ready = 1'b0;
    send_word(32'h33, 1'b0, 0);
    send_word(32'h44, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    async_reset();
    bus.out_ready = 1'b1;
    send_word(32'h77, 1'b1, 0);

    // Random words, random last and random idle gaps.
    for (int i = 0; i < 80; i++) begin
      send_word(W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
    end
    if (cur_q.size() != 0) send_word(W'($urandom), 1'b1, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", FW'(exp_q.size()), FW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
